// File: rtl/stream_downsizer.sv
// rtl/stream_downsizer.sv - wide-to-narrow valid/ready stream converter, LSB slice first, per-word beat count.
// Optional one-word prefetch slot for bubble-free throughput: STREAM_DOWNSIZER_PREFETCH_EN.
module stream_downsizer #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16,
    parameter int RATIO     = IN_WIDTH / OUT_WIDTH,
    parameter int CNT_WIDTH = $clog2(RATIO + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vld_in,
    input  logic [IN_WIDTH-1:0]  data_in,
    input  logic [CNT_WIDTH-1:0] len_in,
    output logic                 rdy_in,
    output logic                 vld_out,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 last_out,
    input  logic                 rdy_out
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IN_WIDTH-1:0]  shreg;
    logic [CNT_WIDTH-1:0] rem;
    logic [CNT_WIDTH-1:0] len_norm;
    logic                 in_hs;
    logic                 out_hs;
    logic                 last_hs;
    logic                 load_in;
    logic                 shift;

    // Zero or out-of-range lengths mean a full word.
    always_comb begin
        len_norm = len_in;
        if (len_in == '0 || len_in > CNT_WIDTH'(RATIO))
            len_norm = CNT_WIDTH'(RATIO);
    end

    assign in_hs    = vld_in && rdy_in;
    assign out_hs   = vld_out && rdy_out;
    assign last_hs  = out_hs && (rem == CNT_WIDTH'(1));
    assign vld_out  = (state == SEND);
    assign last_out = (state == SEND) && (rem == CNT_WIDTH'(1));
    // shreg is untouched while idle, so its low slice holds the last beat.
    assign data_out = shreg[OUT_WIDTH-1:0];

`ifdef STREAM_DOWNSIZER_PREFETCH_EN
    logic [IN_WIDTH-1:0]  pend_data;
    logic [CNT_WIDTH-1:0] pend_len;
    logic                 pvld;
    logic                 load_pend;
    logic                 store_pend;

    assign rdy_in     = !pvld;
    assign store_pend = in_hs && (state == SEND) && !last_hs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pvld      <= 1'b0;
            pend_data <= '0;
            pend_len  <= '0;
        end else if (store_pend) begin
            pvld      <= 1'b1;
            pend_data <= data_in;
            pend_len  <= len_norm;
        end else if (load_pend) begin
            pvld      <= 1'b0;
        end
    end
`else
    assign rdy_in = (state == IDLE);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_in   = 1'b0;
        shift     = 1'b0;
`ifdef STREAM_DOWNSIZER_PREFETCH_EN
        load_pend = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (in_hs) begin
                    load_in   = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (out_hs) begin
                    if (!last_hs) begin
                        shift = 1'b1;
                    end else begin
`ifdef STREAM_DOWNSIZER_PREFETCH_EN
                        if (pvld)
                            load_pend = 1'b1;
                        else if (in_hs)
                            load_in = 1'b1;
                        else
                            state_nxt = IDLE;
`else
                        state_nxt = IDLE;
`endif
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg <= '0;
            rem   <= '0;
        end else if (load_in) begin
            shreg <= data_in;
            rem   <= len_norm;
`ifdef STREAM_DOWNSIZER_PREFETCH_EN
        end else if (load_pend) begin
            shreg <= pend_data;
            rem   <= pend_len;
`endif
        end else if (shift) begin
            shreg <= shreg >> OUT_WIDTH;
            rem   <= rem - CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_stream_downsizer.sv
// tb/tb_stream_downsizer.sv - randomized and directed bench for stream_downsizer against a beat-queue reference model.
module tb_stream_downsizer;

    localparam int IW = 64;
    localparam int OW = 16;
    localparam int R  = IW / OW;
    localparam int CW = $clog2(R + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vld_in;
    logic [IW-1:0] data_in;
    logic [CW-1:0] len_in;
    logic          rdy_in;
    logic          vld_out;
    logic [OW-1:0] data_out;
    logic          last_out;
    logic          rdy_out;

    stream_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld_in   (vld_in),
        .data_in  (data_in),
        .len_in   (len_in),
        .rdy_in   (rdy_in),
        .vld_out  (vld_out),
        .data_out (data_out),
        .last_out (last_out),
        .rdy_out  (rdy_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] d;
        logic          l;
    } beat_t;

    beat_t   exp_q[$];
    int      acc_q[$];
    int      beat_q[$];
    int      cyc = 0;
    int      outstanding = 0;
    int      n_chk = 0;
    int      n_pass = 0;
    bit      prev_stall = 0;
    logic [OW-1:0] prev_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference model: each accepted word becomes its list of expected beats.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            outstanding = 0;
            prev_stall  = 0;
        end else begin
            if (prev_stall) begin
                check("stall_vld", 64'(vld_out), 64'd1);
                check("stall_data", 64'(data_out), 64'(prev_data));
            end
`ifdef STREAM_DOWNSIZER_PREFETCH_EN
            check("rdy_in", 64'(rdy_in), 64'(outstanding < 2));
`else
            check("rdy_in", 64'(rdy_in), 64'(outstanding == 0));
`endif
            check("vld_out", 64'(vld_out), 64'(outstanding > 0));
            if (vld_in && rdy_in) begin
                int n;
                n = (len_in == 0 || len_in > R) ? R : int'(len_in);
                for (int k = 0; k < n; k++) begin
                    beat_t e;
                    e.d = data_in[k*OW +: OW];
                    e.l = (k == n - 1);
                    exp_q.push_back(e);
                end
                acc_q.push_back(cyc);
                outstanding++;
            end
            if (vld_out && rdy_out) begin
                check("beat_avail", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", 64'(data_out), 64'(e.d));
                    check("beat_last", 64'(last_out), 64'(e.l));
                    if (e.l) outstanding--;
                end
                beat_q.push_back(cyc);
            end
            prev_stall = vld_out && !rdy_out;
            prev_data  = data_out;
        end
    end

    task automatic send_word(input logic [IW-1:0] d, input logic [CW-1:0] l, input bit keep);
        bit done;
        done    = 0;
        vld_in  = 1'b1;
        data_in = d;
        len_in  = l;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (rdy_in) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) check("send_timeout", 64'd0, 64'd1);
        if (!keep) vld_in = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done    = 0;
        rdy_out = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (outstanding == 0 && !vld_out) done = 1;
        end
        check("drain", 64'(done), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        acc_q.delete();
        beat_q.delete();
    endtask

    initial begin
        rst_n   = 1'b0;
        vld_in  = 1'b0;
        data_in = '0;
        len_in  = '0;
        rdy_out = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld_out", 64'(vld_out), 64'd0);
        check("rst_last_out", 64'(last_out), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_rdy_in", 64'(rdy_in), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full word: first beat one cycle after acceptance, one beat per cycle.
        clear_log();
        send_word(64'h4444_3333_2222_1111, 3'd4, 0);
        drain();
        check("full_nbeats", 64'(beat_q.size()), 64'd4);
        if (beat_q.size() == 4 && acc_q.size() == 1)
            for (int i = 0; i < 4; i++)
                check("full_timing", 64'(beat_q[i]), 64'(acc_q[0] + 1 + i));

        // Partial word.
        clear_log();
        send_word(64'hDDDD_CCCC_BBBB_AAAA, 3'd2, 0);
        drain();
        check("part_nbeats", 64'(beat_q.size()), 64'd2);
        check("part_idle_after", 64'(vld_out), 64'd0);

        // Backpressure on the second beat.
        send_word(64'h4444_3333_2222_1111, 3'd4, 0);
        @(posedge clk);
        #1;
        rdy_out = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_data", 64'(data_out), 64'h2222);
            check("bp_vld", 64'(vld_out), 64'd1);
            @(posedge clk);
            #1;
        end
        rdy_out = 1'b1;
        @(negedge clk);
        check("bp_data4", 64'(data_out), 64'h2222);
        @(posedge clk);
        #1;
        drain();

        // Back-to-back full words with vld_in held.
        clear_log();
        send_word(64'h4444_3333_2222_1111, 3'd4, 1);
        send_word(64'h8888_7777_6666_5555, 3'd4, 0);
        drain();
        check("b2b_nbeats", 64'(beat_q.size()), 64'd8);
        if (beat_q.size() == 8) begin
`ifdef STREAM_DOWNSIZER_PREFETCH_EN
            check("b2b_span", 64'(beat_q[7] - beat_q[0]), 64'd7);
`else
            check("b2b_span", 64'(beat_q[7] - beat_q[0]), 64'd8);
`endif
        end

        // Reset after two beats, with a second word offered.
        send_word(64'h4444_3333_2222_1111, 3'd4, 0);
        vld_in  = 1'b1;
        data_in = 64'h8888_7777_6666_5555;
        len_in  = 3'd4;
        @(posedge clk);
        #1;
        vld_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_vld_out", 64'(vld_out), 64'd0);
        check("mrst_data_out", 64'(data_out), 64'd0);
        check("mrst_rdy_in", 64'(rdy_in), 64'd1);
        rst_n = 1'b1;
        clear_log();
        repeat (10) @(posedge clk);
        #1;
        check("mrst_no_beats", 64'(beat_q.size()), 64'd0);

        // Length clamping.
        clear_log();
        send_word(64'h0D0D_0C0C_0B0B_0A0A, 3'd0, 0);
        drain();
        check("clamp0_nbeats", 64'(beat_q.size()), 64'd4);
        clear_log();
        send_word(64'h1D1D_1C1C_1B1B_1A1A, 3'd7, 0);
        drain();
        check("clamp7_nbeats", 64'(beat_q.size()), 64'd4);

        // Random traffic with random backpressure.
        for (int i = 0; i < 2000; i++) begin
            bit took;
            @(negedge clk);
            took = vld_in && rdy_in;
            @(posedge clk);
            #1;
            rdy_out = ($urandom_range(3) != 0);
            if (took || !vld_in) begin
                if ($urandom_range(2) != 0) begin
                    vld_in  = 1'b1;
                    data_in = {$urandom, $urandom};
                    len_in  = CW'($urandom_range(7));
                end else begin
                    vld_in = 1'b0;
                end
            end
        end
        vld_in = 1'b0;
        drain();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
